// File: rtl/furv_pkg.sv
// Shared definitions for the fetch front end: machine width, buffer entry layout,
// bus FSM states and small address helpers.
package furv_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_DROP
    } bus_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
        return a + XLEN'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Instruction memory read bus: single outstanding request, held until acknowledged.
interface ifetch_prefetch_if;
    import furv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/ifetch_buf.sv
// DEPTH-entry circular buffer of fetched words; exposes the head and the entry behind it.
module ifetch_buf
    import furv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output fetch_entry_t             head_next,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   wr_ptr;

    // A flush that coincides with a push restarts the buffer with that word at slot 0.
    assign wr_ptr = flush ? '0 : tail_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= PW'(push);
            count_reg <= CW'(push);
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head      = mem[head_reg];
    assign head_next = mem[head_reg + PW'(1)];
    assign count     = count_reg;

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetch stage: follows the core pc, streams sequential words into a small buffer
// and redirects on any non-sequential pc.
module ifetch_prefetch
    import furv_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   instruction,
    output logic              instr_valid,
    ifetch_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    bus_state_t      state_reg, state_next;
    logic [XLEN-1:0] fetch_addr_reg, fetch_addr_next;
    logic [XLEN-1:0] addr_reg, addr_next;

    fetch_entry_t    head, head_next, wdata;
    logic [CW-1:0]   count, count_eff;
    logic [XLEN-1:0] pc_w, fetch_base;
    logic            empty, head_match, next_match, inflight_match;
    logic            flush, pop, acked, push, room;

    assign pc_w           = word_align(pc);
    assign empty          = (count == '0);
    assign head_match     = !empty && (head.addr == pc_w);
    assign next_match     = (count >= CW'(2)) && (head_next.addr == pc_w);
    assign inflight_match = (state_reg == REQ) && (addr_reg == pc_w);

    assign pop   = !head_match && next_match;
    assign flush = (!empty && !head_match && !next_match) ||
                   (empty && (fetch_addr_reg != pc_w) && !inflight_match);

    // Returning data survives a redirect only when it is exactly the new target.
    assign acked = (state_reg != IDLE) && bus.imem_ack;
    assign push  = acked && (state_reg == REQ) && (!flush || (addr_reg == pc_w));
    assign wdata = {addr_reg, bus.imem_rdata};

    assign fetch_base = flush ? (push ? next_word(pc_w) : pc_w) : fetch_addr_reg;
    assign count_eff  = flush ? CW'(push) : (count + CW'(push) - CW'(pop));
    assign room       = (count_eff < CW'(DEPTH));

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_base;
        addr_next       = addr_reg;
        case (state_reg)
            IDLE: begin
                if (room) begin
                    state_next      = REQ;
                    addr_next       = fetch_base;
                    fetch_addr_next = next_word(fetch_base);
                end
            end
            default: begin
                if (acked) begin
                    if (room) begin
                        state_next      = REQ;
                        addr_next       = fetch_base;
                        fetch_addr_next = next_word(fetch_base);
                    end else begin
                        state_next = IDLE;
                    end
                end else if (flush) begin
                    state_next = REQ_DROP;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            fetch_addr_reg <= RESET_PC;
            addr_reg       <= RESET_PC;
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
            addr_reg       <= addr_next;
        end
    end

    ifetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (wdata),
        .head      (head),
        .head_next (head_next),
        .count     (count)
    );

    assign bus.imem_req  = (state_reg != IDLE);
    assign bus.imem_addr = addr_reg;
    assign instr_valid   = head_match;
    assign instruction   = head_match ? head.data : '0;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed and randomized bench for ifetch_prefetch against a queue-based reference model.
module tb_ifetch_prefetch;
    import furv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = RPC;
    logic [31:0] instruction;
    logic        instr_valid;

    ifetch_prefetch_if bus();

    ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffer as a queue, one pending request, a drop flag.
    fetch_entry_t q[$];
    bit           m_req, m_drop;
    logic [31:0]  m_addr, m_fetch;
    int           wait_left, minw, maxw;
    bit           last_valid, dut_valid;
    logic [31:0]  cur;
    int           r;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_req = 0; m_drop = 0; m_addr = RPC; m_fetch = RPC; wait_left = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_valid"}, instr_valid, 1'b0);
        check32({tag, "_instr"}, instruction, 32'h0);
        check1({tag, "_req"}, bus.imem_req, 1'b0);
        check32({tag, "_addr"}, bus.imem_addr, RPC);
    endtask

    // Leaves time at posedge+1 with rst low.
    task automatic do_reset();
        rst = 1'b1; pc = RPC; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    // One clock cycle: drive, compare at mid-cycle, advance model, move to posedge+1.
    task automatic step(input logic [31:0] p);
        logic [31:0]  pw;
        bit           ack, exp_v, hm, nm, inm, fl, saved, prev_req;
        fetch_entry_t e;
        pw = {p[31:2], 2'b00};
        pc = p;
        ack = m_req && (wait_left == 0);
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(m_addr) : $urandom();
        #4;
        exp_v = (q.size() > 0) && (q[0].addr == pw);
        check1("instr_valid", instr_valid, exp_v);
        check32("instruction", instruction, exp_v ? q[0].data : 32'h0);
        check1("imem_req", bus.imem_req, m_req);
        check32("imem_addr", bus.imem_addr, m_addr);
        last_valid = exp_v;
        dut_valid  = instr_valid;

        hm  = (q.size() > 0) && (q[0].addr == pw);
        nm  = (q.size() >= 2) && (q[1].addr == pw);
        inm = m_req && !m_drop && (m_addr == pw);
        fl  = ((q.size() > 0) && !hm && !nm) || ((q.size() == 0) && (m_fetch != pw) && !inm);
        saved = ack && !m_drop && (!fl || (m_addr == pw));
        if (ack)
            $display("txn addr=%h data=%h pc=%h %s", m_addr, mem_word(m_addr), pw,
                     saved ? "kept" : "dropped");
        if (fl) begin
            q.delete();
            m_fetch = pw;
        end else if (nm && !hm) begin
            void'(q.pop_front());
        end
        if (saved) begin
            e.addr = m_addr; e.data = mem_word(m_addr);
            q.push_back(e);
            if (fl) m_fetch = pw + 32'd4;
        end
        prev_req = m_req;
        if (m_req && !ack) begin
            if (fl) m_drop = 1;
        end else begin
            m_drop = 0;
            if (q.size() < DEPTH) begin
                m_req = 1; m_addr = m_fetch; m_fetch = m_fetch + 32'd4;
            end else begin
                m_req = 0;
            end
        end
        if (prev_req && !ack) wait_left--;
        if (m_req && (!prev_req || ack)) wait_left = $urandom_range(maxw, minw);
        @(posedge clk); #1;
    endtask

    task automatic run_until_valid(input logic [31:0] p, input int bound, input string tag);
        int n = 0;
        do begin
            step(p);
            n++;
        end while (!dut_valid && n < bound);
        check1(tag, dut_valid, 1'b1);
    endtask

    initial begin
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        minw = 0; maxw = 0;
        do_reset();

        // Zero-wait memory, core advances whenever it has a valid word.
        cur = RPC;
        repeat (30) begin
            step(cur);
            if (last_valid) cur = cur + 32'd4;
        end

        // Slow memory: request held for three cycles before the ack.
        do_reset();
        minw = 3; maxw = 3;
        repeat (12) step(32'h0);

        // Redirect while a request is outstanding.
        minw = 0; maxw = 0;
        repeat (6) step(32'h10);
        minw = 3; maxw = 3;
        step(32'h14);
        step(32'h14);
        run_until_valid(32'h100, 20, "t3_valid_0x100");

        // Branch that lands on the word being acknowledged in the same cycle.
        minw = 0; maxw = 0;
        repeat (6) step(32'h38);
        step(32'h3C);
        step(32'h40);
        check32("t4_next_req_addr", bus.imem_addr, 32'h44);
        step(32'h40);

        // Held pc fills the buffer and the bus goes idle.
        repeat (8) step(32'h20);
        check1("t5_req_idle", bus.imem_req, 1'b0);

        // Sequential stream across the 32-bit wrap.
        minw = 0; maxw = 1;
        cur = 32'hFFFF_FFF0;
        repeat (24) begin
            step(cur);
            if (last_valid) cur = cur + 32'd4;
        end

        // Randomized traffic: variable latency, branches, junk low pc bits.
        minw = 0; maxw = 3;
        cur = 32'h200;
        repeat (600) begin
            step(cur);
            r = $urandom_range(99);
            if (r < 8) begin
                if (m_req && r < 3) cur = m_addr;
                else if (r == 7) cur = 32'hFFFF_FFF4;
                else cur = 32'h200 + 32'($urandom_range(0, 63)) * 32'd4;
            end else if (last_valid) begin
                cur = cur + 32'd4;
            end
            cur[1:0] = 2'($urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        minw = 0; maxw = 0;
        repeat (5) step(32'h0);
        minw = 3; maxw = 3;
        step(32'h4);
        r = 0;
        while (!(m_req && wait_left > 0) && r < 20) begin
            step(32'h4);
            r++;
        end
        check1("t6_req_pending", bus.imem_req, 1'b1);
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        minw = 0; maxw = 0;
        run_until_valid(RPC, 10, "t6_refetch_valid");
        cur = RPC;
        repeat (8) begin
            step(cur);
            if (last_valid) cur = cur + 32'd4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
